// File: rtl/i2s_tx_pkg.sv
// Shared audio definitions for the I2S transmitter: sample width, default
// timing and the output format encodings, plus the slot-to-bit selector.
package i2s_tx_pkg;

  localparam int SAMPLE_W         = 24;
  localparam int DEF_CLKS_PER_BCK = 8;
  localparam int DEF_SLOTS        = 32;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // I2S delays the MSB by one slot; left-justified puts it in slot 0.
  function automatic logic slot_bit(input sample_t s, input fmt_e fmt,
                                    input logic [31:0] slot);
    logic [31:0] idx;
    logic [4:0]  bi;
    idx = (fmt == FMT_LJ) ? slot : slot - 32'd1;
    bi  = 5'(SAMPLE_W - 1) - idx[4:0];
    if (fmt == FMT_I2S && slot == 32'd0) return 1'b0;
    if (idx >= 32'(SAMPLE_W)) return 1'b0;
    return s[bi];
  endfunction

endpackage

// File: rtl/i2s_slot_timer.sv
// Frame counter kept as mixed-radix phase/slot/half fields. Exposes the
// upcoming position so the parent can register outputs aligned with it.
module i2s_slot_timer
  import i2s_tx_pkg::*;
#(
  parameter int CLKS_PER_BCK = DEF_CLKS_PER_BCK,
  parameter int SLOTS        = DEF_SLOTS,
  localparam int PW          = $clog2(CLKS_PER_BCK),
  localparam int SW          = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] phase_nxt,
  output logic [SW-1:0] slot_nxt,
  output logic          half_nxt,
  output logic          next_sample
);

  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          half_q, half_d;
  logic          next_sample_q, next_sample_d;

  // NOTE: every signal assigned here gets its default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    phase_d = phase_q + PW'(1);
    slot_d  = slot_q;
    half_d  = half_q;
    if (phase_q == PW'(CLKS_PER_BCK - 1)) begin
      phase_d = '0;
      if (slot_q == SW'(SLOTS - 1)) begin
        slot_d = '0;
        half_d = ~half_q;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
    next_sample_d = (phase_d == PW'(CLKS_PER_BCK - 1)) &&
                    (slot_d == SW'(SLOTS - 1)) && half_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= '0;
      slot_q        <= '0;
      half_q        <= 1'b0;
      next_sample_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      slot_q        <= slot_d;
      half_q        <= half_d;
      next_sample_q <= next_sample_d;
    end
  end

  assign phase_nxt   = phase_d;
  assign slot_nxt    = slot_d;
  assign half_nxt    = half_d;
  assign next_sample = next_sample_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified serial transmitter: captures one stereo sample per
// frame and shifts it out over the following frame with registered outputs.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int CLKS_PER_BCK = DEF_CLKS_PER_BCK,
  parameter int SLOTS        = DEF_SLOTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] left_data,
  input  logic [SAMPLE_W-1:0] right_data,
  input  logic                lj_mode,
  input  logic                mute,
  output logic                next_sample,
  output logic                i2s_lrck,
  output logic                i2s_bck,
  output logic                i2s_data
);

  localparam int PW = $clog2(CLKS_PER_BCK);
  localparam int SW = $clog2(SLOTS);

  logic [PW-1:0] phase_nxt;
  logic [SW-1:0] slot_nxt;
  logic          half_nxt;
  logic          load;

  i2s_slot_timer #(
    .CLKS_PER_BCK(CLKS_PER_BCK),
    .SLOTS       (SLOTS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .phase_nxt  (phase_nxt),
    .slot_nxt   (slot_nxt),
    .half_nxt   (half_nxt),
    .next_sample(load)
  );

  sample_t hold_l_q, hold_l_d;
  sample_t hold_r_q, hold_r_d;
  fmt_e    fmt_q, fmt_d;
  logic    bck_q, bck_d;
  logic    lrck_q, lrck_d;
  logic    data_q, data_d;

  // Outputs are computed for the upcoming count, using the freshly loaded
  // sample at the frame boundary, so they line up with the counter.
  always_comb begin
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    fmt_d    = fmt_q;
    if (load) begin
      hold_l_d = mute ? '0 : left_data;
      hold_r_d = mute ? '0 : right_data;
      fmt_d    = fmt_e'(lj_mode);
    end
    bck_d  = (phase_nxt >= PW'(CLKS_PER_BCK / 2));
    lrck_d = half_nxt;
    data_d = slot_bit(half_nxt ? hold_r_d : hold_l_d, fmt_d, 32'(slot_nxt));
  end

  // NOTE: the hold registers are plain flops, not a memory, so they take the
  // async reset like everything else and start each run with silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      fmt_q    <= FMT_I2S;
      bck_q    <= 1'b0;
      lrck_q   <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      fmt_q    <= fmt_d;
      bck_q    <= bck_d;
      lrck_q   <= lrck_d;
      data_q   <= data_d;
    end
  end

  assign next_sample = load;
  assign i2s_bck     = bck_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_data    = data_q;

endmodule
